// File: rtl/fx2_slave_fifo_emu_pkg.sv
// Shared constants for the FX2 slave-FIFO emulation: endpoint codes, strobe polarity, error bits.
package fx2_slave_fifo_emu_pkg;

    typedef logic [15:0] fx2_word_t;

    localparam logic [1:0] FX2_EP2_ADR = 2'b00;
    localparam logic [1:0] FX2_EP6_ADR = 2'b10;

    // SLRD/SLWR/SLOE/PKEND are all active low on the FX2 pins
    localparam logic SL_ASSERT = 1'b0;

    localparam int unsigned ERR_W             = 3;
    localparam int unsigned ERR_EP2_UNDERFLOW = 0;
    localparam int unsigned ERR_EP6_OVERFLOW  = 1;
    localparam int unsigned ERR_STROBE_CLASH  = 2;

endpackage

// File: rtl/fx2_slave_fifo_emu_if.sv
// FX2 slave-FIFO control strobes and flags; the data bus FX2_FD stays a plain inout port.
interface fx2_slave_fifo_emu_if;

    logic [1:0] FIFO_ADR;
    logic       SLRD;
    logic       SLWR;
    logic       SLOE;
    logic       PKEND;
    logic       FLAGA;
    logic       FLAGC;

    modport master (
        output FIFO_ADR, SLRD, SLWR, SLOE, PKEND,
        input  FLAGA, FLAGC
    );

    modport slave (
        input  FIFO_ADR, SLRD, SLWR, SLOE, PKEND,
        output FLAGA, FLAGC
    );

endinterface

// File: rtl/fx2_slave_fifo_emu_ep_fifo.sv
// Single-clock show-ahead 16-bit FIFO used for each FX2 endpoint buffer.
module fx2_slave_fifo_emu_ep_fifo
    import fx2_slave_fifo_emu_pkg::*;
#(
    parameter int unsigned DEPTH = 2048
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  fx2_word_t               din,
    input  logic                    pop,
    output fx2_word_t               head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fx2_word_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push_ok_c;
    logic           pop_ok_c;

    assign push_ok_c = push && (count != CW'(DEPTH));
    assign pop_ok_c  = pop && (count != '0);
    assign head      = mem[rd_ptr];

    // Pointer and occupancy tracking; push and pop in one cycle leave the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok_c, pop_ok_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, not reset; contents are only visible through a valid count
    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fx2_slave_fifo_emu.sv
// FX2 slave-FIFO emulation: EP2 (host -> bus master) and EP6 (bus master -> host, packet committed).
module fx2_slave_fifo_emu
    import fx2_slave_fifo_emu_pkg::*;
#(
    parameter int unsigned EP_DEPTH  = 2048,
    parameter int unsigned PKT_WORDS = 512,
    parameter logic [1:0]  EP2_ADR   = FX2_EP2_ADR,
    parameter logic [1:0]  EP6_ADR   = FX2_EP6_ADR
) (
    input  logic                       IFCLK,
    input  logic                       IF_reset_n,
    inout  wire  [15:0]                FX2_FD,
    fx2_slave_fifo_emu_if.slave        bus,
    input  logic                       host_wr,
    input  fx2_word_t                  host_wdata,
    output logic [$clog2(EP_DEPTH):0]  host_ep2_free,
    input  logic                       host_rd,
    output fx2_word_t                  host_rdata,
    output logic [$clog2(EP_DEPTH):0]  host_ep6_avail,
    output logic [ERR_W-1:0]           err_sticky
);

    localparam int unsigned CW      = $clog2(EP_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(EP_DEPTH);
    localparam logic [CW-1:0] PKT_C   = CW'(PKT_WORDS);

    logic [CW-1:0] ep2_cnt;
    logic [CW-1:0] ep6_cnt;
    logic [CW-1:0] ep6_uncom;
    logic [CW-1:0] ep6_com;
    logic [CW-1:0] uncom_sum_c;
    fx2_word_t     ep2_head;
    fx2_word_t     ep6_head;
    logic          rd_req_c;
    logic          wr_req_c;
    logic          clash_c;
    logic          pkend_c;
    logic          ep2_pop_c;
    logic          ep2_push_c;
    logic          ep6_push_c;
    logic          ep6_pop_c;
    logic          commit_c;
    logic          fd_oe_c;
    logic          flag_a;
    logic          flag_c;

    // Strobe decode; a strobe aimed at the other endpoint is silently ignored
    assign clash_c   = (bus.SLRD == SL_ASSERT) && (bus.SLWR == SL_ASSERT);
    assign rd_req_c  = (bus.SLRD == SL_ASSERT) && (bus.SLWR != SL_ASSERT) && (bus.FIFO_ADR == EP2_ADR);
    assign wr_req_c  = (bus.SLWR == SL_ASSERT) && (bus.SLRD != SL_ASSERT) && (bus.FIFO_ADR == EP6_ADR);
    assign pkend_c   = (bus.PKEND == SL_ASSERT) && (bus.FIFO_ADR == EP6_ADR);

    assign ep2_pop_c  = rd_req_c && (ep2_cnt != '0);
    assign ep2_push_c = host_wr && (ep2_cnt != DEPTH_C);
    assign ep6_push_c = wr_req_c && (ep6_cnt != DEPTH_C);
    assign ep6_pop_c  = host_rd && (ep6_com != '0);

    // Packet commit: full packet, or PKEND with something pending (no zero-length packets)
    assign uncom_sum_c = ep6_uncom + CW'(ep6_push_c);
    assign commit_c    = (uncom_sum_c == PKT_C) || (pkend_c && (uncom_sum_c != '0));

    // Bus driver: EP2 head while output-enabled, zero when empty, released during reset
    assign fd_oe_c = IF_reset_n && (bus.SLOE == SL_ASSERT) && (bus.FIFO_ADR == EP2_ADR);
    assign FX2_FD  = fd_oe_c ? ((ep2_cnt != '0) ? ep2_head : 16'h0000) : 16'hzzzz;

    assign host_ep2_free  = DEPTH_C - ep2_cnt;
    assign host_ep6_avail = ep6_com;
    assign host_rdata     = (ep6_com != '0) ? ep6_head : 16'h0000;
    assign bus.FLAGA      = flag_a;
    assign bus.FLAGC      = flag_c;

    fx2_slave_fifo_emu_ep_fifo #(.DEPTH(EP_DEPTH)) u_ep2 (
        .clk   (IFCLK),
        .rst_n (IF_reset_n),
        .push  (ep2_push_c),
        .din   (host_wdata),
        .pop   (ep2_pop_c),
        .head  (ep2_head),
        .count (ep2_cnt)
    );

    fx2_slave_fifo_emu_ep_fifo #(.DEPTH(EP_DEPTH)) u_ep6 (
        .clk   (IFCLK),
        .rst_n (IF_reset_n),
        .push  (ep6_push_c),
        .din   (FX2_FD),
        .pop   (ep6_pop_c),
        .head  (ep6_head),
        .count (ep6_cnt)
    );

    // EP6 split into committed (host-visible) and uncommitted words
    always_ff @(posedge IFCLK or negedge IF_reset_n) begin
        if (!IF_reset_n) begin
            ep6_uncom <= '0;
            ep6_com   <= '0;
        end else begin
            ep6_uncom <= commit_c ? '0 : uncom_sum_c;
            ep6_com   <= ep6_com - CW'(ep6_pop_c) + (commit_c ? uncom_sum_c : '0);
        end
    end

    // Flags follow the registered counts, giving one IFCLK of flag latency
    always_ff @(posedge IFCLK or negedge IF_reset_n) begin
        if (!IF_reset_n) begin
            flag_a <= 1'b0;
            flag_c <= 1'b1;
        end else begin
            flag_a <= (ep2_cnt >= PKT_C);
            flag_c <= ((DEPTH_C - ep6_cnt) >= PKT_C);
        end
    end

    // Sticky protocol error capture
    always_ff @(posedge IFCLK or negedge IF_reset_n) begin
        if (!IF_reset_n) begin
            err_sticky <= '0;
        end else begin
            if (rd_req_c && (ep2_cnt == '0))      err_sticky[ERR_EP2_UNDERFLOW] <= 1'b1;
            if (wr_req_c && (ep6_cnt == DEPTH_C)) err_sticky[ERR_EP6_OVERFLOW]  <= 1'b1;
            if (clash_c)                          err_sticky[ERR_STROBE_CLASH]  <= 1'b1;
        end
    end

endmodule
